// File: rtl/regfile_wb.sv
// Integer register file fed by the write-back stage, with bypassed decode read
// ports, a registered debug read port and a per-register pending-write scoreboard.
module regfile_wb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int PW    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] wb_data,
    input  logic [AW-1:0]   wb_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            issue_we,
    input  logic [AW-1:0]   issue_rd,
    output logic            pend1,
    output logic            pend2,
    output logic            sb_ovf,
    output logic            sb_unf,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam logic [PW-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] CNT_ONE = PW'(1);

    logic [XLEN-1:0] regs [NREGS];
    logic [PW-1:0]   cnt  [NREGS];

    logic            inc;
    logic            dec;
    logic            same;
    logic [XLEN-1:0] dbg_next;

    assign inc  = issue_we && (issue_rd != '0);
    assign dec  = wb_regwrite && (wb_rd != '0);
    assign same = inc && dec && (issue_rd == wb_rd);

    function automatic logic [XLEN-1:0] read_val(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored,
        input logic            we,
        input logic [AW-1:0]   rd,
        input logic [XLEN-1:0] data
    );
        logic [XLEN-1:0] val;
        if (addr == '0)
            val = '0;
        else if (we && (rd == addr))
            val = data;
        else
            val = stored;
        return val;
    endfunction

    // The last in-flight write landing this cycle is already served by the bypass.
    function automatic logic pend_of(
        input logic [AW-1:0] addr,
        input logic [PW-1:0] count,
        input logic          dec_now,
        input logic [AW-1:0] rd
    );
        logic p;
        if (addr == '0)
            p = 1'b0;
        else if (count > CNT_ONE)
            p = 1'b1;
        else if (count == CNT_ONE)
            p = !(dec_now && (rd == addr));
        else
            p = 1'b0;
        return p;
    endfunction

    always_comb begin
        rdata1   = read_val(rs1, regs[rs1], wb_regwrite, wb_rd, wb_data);
        rdata2   = read_val(rs2, regs[rs2], wb_regwrite, wb_rd, wb_data);
        dbg_next = read_val(dbg_addr, regs[dbg_addr], wb_regwrite, wb_rd, wb_data);
        pend1    = pend_of(rs1, cnt[rs1], dec, wb_rd);
        pend2    = pend_of(rs2, cnt[rs2], dec, wb_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_ovf   <= 1'b0;
            sb_unf   <= 1'b0;
            dbg_data <= '0;
        end else begin
            dbg_data <= dbg_next;
            if (dec)
                regs[wb_rd] <= wb_data;
            // An issue and a retire on the same register cancel out.
            if (inc && !same) begin
                if (cnt[issue_rd] == CNT_MAX)
                    sb_ovf <= 1'b1;
                else
                    cnt[issue_rd] <= cnt[issue_rd] + CNT_ONE;
            end
            if (dec && !same) begin
                if (cnt[wb_rd] == '0)
                    sb_unf <= 1'b1;
                else
                    cnt[wb_rd] <= cnt[wb_rd] - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed scenarios plus random traffic, checked by a
// queue-based scoreboard against an array-level reference model.
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic        wb_regwrite;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic        pend1;
    logic        pend2;
    logic        sb_ovf;
    logic        sb_unf;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    regfile_wb dut (
        .clk        (clk),
        .rst        (rst),
        .wb_regwrite(wb_regwrite),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .issue_we   (issue_we),
        .issue_rd   (issue_rd),
        .pend1      (pend1),
        .pend2      (pend2),
        .sb_ovf     (sb_ovf),
        .sb_unf     (sb_unf),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] dbg;
        logic        p1;
        logic        p2;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [31:0] m_reg [32];
    int          m_cnt [32];
    logic        m_ovf;
    logic        m_unf;
    logic [31:0] m_dbg;

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] rd, input logic [31:0] d);
        if (a == 0) return 32'h0;
        if (we && rd == a) return d;
        return m_reg[a];
    endfunction

    function automatic logic m_pend(input logic [4:0] a, input logic we, input logic [4:0] rd);
        bit retiring;
        if (a == 0) return 1'b0;
        retiring = we && (rd != 0) && (rd == a);
        return (m_cnt[a] > 1) || (m_cnt[a] == 1 && !retiring);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: drive, push expectation, then advance the model.
    task automatic cyc(input logic r, input logic we, input logic [31:0] d, input logic [4:0] rd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic iw, input logic [4:0] ird, input logic [4:0] da);
        exp_t e;
        bit   inc, dec;
        @(posedge clk);
        #1;
        rst = r; wb_regwrite = we; wb_data = d; wb_rd = rd;
        rs1 = a1; rs2 = a2; issue_we = iw; issue_rd = ird; dbg_addr = da;

        e.r1  = m_read(a1, we, rd, d);
        e.r2  = m_read(a2, we, rd, d);
        e.p1  = m_pend(a1, we, rd);
        e.p2  = m_pend(a2, we, rd);
        e.ovf = m_ovf;
        e.unf = m_unf;
        e.dbg = m_dbg;
        q.push_back(e);

        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 32'h0;
                m_cnt[i] = 0;
            end
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_dbg = 32'h0;
        end else begin
            m_dbg = m_read(da, we, rd, d);
            inc = iw && ird != 0;
            dec = we && rd != 0;
            if (!(inc && dec && ird == rd)) begin
                if (inc) begin
                    if (m_cnt[ird] == 3) m_ovf = 1'b1;
                    else m_cnt[ird] = m_cnt[ird] + 1;
                end
                if (dec) begin
                    if (m_cnt[rd] == 0) m_unf = 1'b1;
                    else m_cnt[rd] = m_cnt[rd] - 1;
                end
            end
            if (dec) m_reg[rd] = d;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rdata1", rdata1, e.r1);
                chk("rdata2", rdata2, e.r2);
                chk("pend1", {31'h0, pend1}, {31'h0, e.p1});
                chk("pend2", {31'h0, pend2}, {31'h0, e.p2});
                chk("sb_ovf", {31'h0, sb_ovf}, {31'h0, e.ovf});
                chk("sb_unf", {31'h0, sb_unf}, {31'h0, e.unf});
                chk("dbg_data", dbg_data, e.dbg);
            end
        end
    end

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 5));
    endfunction

    initial begin : driver
        rst = 1'b1; wb_regwrite = 1'b0; wb_data = 32'h0; wb_rd = 5'd0;
        rs1 = 5'd0; rs2 = 5'd0; issue_we = 1'b0; issue_rd = 5'd0; dbg_addr = 5'd0;
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'h0;
            m_cnt[i] = 0;
        end
        m_ovf = 1'b0; m_unf = 1'b0; m_dbg = 32'h0;
        repeat (2) @(posedge clk);

        // Post-reset sweep of both read ports
        for (int i = 0; i < 32; i++)
            cyc(0, 0, 32'h0, 5'd0, 5'(i), 5'(31 - i), 0, 5'd0, 5'(i));

        // Bypass then stored read of x5
        cyc(0, 1, 32'hDEADBEEF, 5'd5, 5'd5, 5'd0, 0, 5'd0, 5'd5);
        cyc(0, 0, 32'h0, 5'd0, 5'd0, 5'd5, 0, 5'd0, 5'd5);

        // x0 is never written and issue to x0 is ignored
        cyc(0, 1, 32'h12345678, 5'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0);
        cyc(0, 0, 32'h0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 5'd0);
        cyc(0, 0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0);

        // Two in-flight writes to x7
        cyc(0, 0, 32'h0, 5'd0, 5'd7, 5'd7, 1, 5'd7, 5'd7);
        cyc(0, 0, 32'h0, 5'd0, 5'd7, 5'd7, 1, 5'd7, 5'd7);
        cyc(0, 1, 32'h11, 5'd7, 5'd7, 5'd7, 0, 5'd0, 5'd7);
        cyc(0, 1, 32'h22, 5'd7, 5'd7, 5'd7, 0, 5'd0, 5'd7);
        cyc(0, 0, 32'h0, 5'd0, 5'd7, 5'd7, 0, 5'd0, 5'd7);

        // Concurrent issue+retire on x9, drain, then overflow; underflow on x10
        cyc(0, 0, 32'h0, 5'd0, 5'd9, 5'd9, 1, 5'd9, 5'd9);
        cyc(0, 1, 32'h99, 5'd9, 5'd9, 5'd9, 1, 5'd9, 5'd9);
        cyc(0, 1, 32'h98, 5'd9, 5'd9, 5'd9, 0, 5'd0, 5'd9);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 32'h0, 5'd0, 5'd9, 5'd0, 1, 5'd9, 5'd9);
        cyc(0, 1, 32'hA0, 5'd10, 5'd10, 5'd9, 0, 5'd0, 5'd10);
        cyc(0, 0, 32'h0, 5'd0, 5'd10, 5'd9, 0, 5'd0, 5'd10);

        // Reset mid-operation with a concurrent write-back to x3
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 32'h0, 5'd0, 5'd3, 5'd3, 1, 5'd3, 5'd3);
        cyc(0, 1, 32'hAA, 5'd3, 5'd3, 5'd3, 0, 5'd0, 5'd3);
        cyc(1, 1, 32'h55, 5'd3, 5'd3, 5'd3, 1, 5'd3, 5'd3);
        cyc(0, 0, 32'h0, 5'd0, 5'd3, 5'd3, 0, 5'd0, 5'd3);
        cyc(0, 0, 32'h0, 5'd0, 5'd3, 5'd3, 0, 5'd0, 5'd3);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 399) == 0),
                ($urandom_range(0, 1) == 1), $urandom, rnd_addr(),
                rnd_addr(), rnd_addr(),
                ($urandom_range(0, 1) == 1), rnd_addr(), rnd_addr());
        end

        @(posedge clk);
        #1;
        rst = 1'b0; wb_regwrite = 1'b0; issue_we = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Integer register file that is the receiving end of the write-back interface (regwrite, write-back data, write-back rd).
- Provides two combinational decode-stage read ports with same-cycle write-back bypass.
- Contains a per-register pending-write scoreboard. Decode uses it to detect reads of registers whose producing instruction has not yet written back.
- Sits between the decode stage (reads, issue) and the write-back stage (writes, retire).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register address width; must satisfy 2**AW == NREGS
PW, 2, width of each per-register pending counter (max in-flight writes per register = 2**PW-1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
wb_regwrite  in  1  write-back enable from write-back stage
wb_data  in  XLEN  write-back data
wb_rd  in  AW  write-back destination register
rs1  in  AW  read port 1 address (decode)
rs2  in  AW  read port 2 address (decode)
rdata1  out  XLEN  read port 1 data, combinational
rdata2  out  XLEN  read port 2 data, combinational
issue_we  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  AW  destination of issued instruction
pend1  out  1  rs1 has an outstanding write not yet visible on rdata1
pend2  out  1  rs2 has an outstanding write not yet visible on rdata2
sb_ovf  out  1  sticky: an issue hit a saturated counter
sb_unf  out  1  sticky: a write-back hit a zero counter
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  debug read data, registered (1-cycle latency)

Behaviour:
- Reset (rst=1 at clock edge): all registers = 0, all pending counters = 0, sb_ovf = 0, sb_unf = 0, dbg_data = 0. Reset has priority over any concurrent write or issue.
- Write: at clock edge, if wb_regwrite && wb_rd != 0, then reg[wb_rd] <= wb_data. Writes to x0 are discarded.
- Read, per port p (rs = rs1/rs2):
  - rs == 0 → 0.
  - else if wb_regwrite && wb_rd == rs → wb_data (bypass).
  - else → reg[rs].
  - Both ports are fully independent and may read the same register.
- Debug read: dbg_data <= value at dbg_addr using the same read rules (x0 = 0, bypass applies), registered one cycle.
- Scoreboard events per cycle:
  - inc = issue_we && issue_rd != 0
  - dec = wb_regwrite && wb_rd != 0
- Counter update for register r:
  - inc only → cnt[r] + 1.
  - dec only → cnt[r] - 1.
  - inc and dec on the same r → unchanged.
  - inc and dec on different registers → both applied.
- Saturation:
  - inc only, cnt == 2**PW-1 → cnt holds; sb_ovf <= 1.
  - dec only, cnt == 0 → cnt holds; sb_unf <= 1.
  - The sticky flags clear only on rst.
- pend, for rs != 0: cnt[rs] > 1, or (cnt[rs] == 1 and not (dec && wb_rd == rs)). A final in-flight write arriving this cycle is covered by the bypass.
- pend for rs == 0: always 0.
- pend depends only on current-cycle state and inputs. A same-cycle issue to rs does not raise pend until the next cycle.

Test Plan:
- Reset then read all rs1/rs2 = 0..31 → rdata = 0, pend = 0, sb flags 0.
- Write x5 = 0xDEADBEEF (regwrite=1, rd=5). Same cycle rs1=5 → rdata1 = 0xDEADBEEF via bypass. Next cycle, regwrite=0, rs2=5 → 0xDEADBEEF.
- Write x0 = 0x12345678, then read rs1=0 → 0 in both the write cycle and the next cycle; issue_rd=0 leaves pend unaffected.
- Issue rd=7 twice (cnt=2) → pend1=1 with rs1=7. First WB to x7 (0x11) → pend1 still 1. Second WB (0x22) → pend1=0 in that cycle and rdata1=0x22.
- Same-cycle issue rd=9 and WB rd=9 with cnt=1 → cnt stays 1. Issue rd=9 four times from 0 → cnt=3 and sb_ovf=1. WB rd=10 with cnt=0 → sb_unf=1.
- rst asserted mid-operation (cnt[3]=2, x3=0xAA, concurrent WB to x3) → next cycle x3=0, pend=0, flags 0; dbg_addr=3 → dbg_data=0 one cycle later.
